// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM
// states and the operand sign/magnitude helper.
package muldiv_pkg;

  // Width the abs_sign helper is built for; the sequencer's DATA_W must match.
  localparam int MD_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } muldiv_state_t;

  // Returns {sign, magnitude}; unsigned ops always report a positive operand.
  function automatic logic [MD_W:0] abs_sign(input logic [MD_W-1:0] value,
                                             input logic            signed_op);
    logic sign;
    sign = signed_op & value[MD_W-1];
    return {sign, (sign ? -value : value)};
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// EX-stage / hazard-unit side of the HI/LO sequencer, bundled as one interface.
interface hilo_muldiv_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              Start;
  logic [2:0]        Op;
  logic [DATA_W-1:0] OperandA;
  logic [DATA_W-1:0] OperandB;
  logic              HiLoRead;
  logic              Kill;
  logic              Busy;
  logic              StallReq;
  logic              Done;
  logic              DivByZero;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output Start, Op, OperandA, OperandB, HiLoRead, Kill,
    input  Busy, StallReq, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, HiLoRead, Kill,
    output Busy, StallReq, Done, DivByZero, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_iter.sv
// One radix-2 step of either an unsigned shift-add multiply or an unsigned
// restoring divide, on a shared 2*DATA_W+1 bit accumulator.
module muldiv_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              is_div,
  output logic [2*DATA_W:0] acc_next,
  output logic              q_bit
);

  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   hi_next;
  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] trial;

  // Multiply layout: {0, partial_hi, multiplier_lo}; divide layout:
  // {remainder[DATA_W:0], dividend/quotient}. For divide the quotient bit is
  // returned separately and the caller merges it into bit 0.
  // NOTE: every output gets a default before the branch so no latch is inferred.
  always_comb begin
    add_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
    hi_next  = acc[0] ? add_sum : {1'b0, acc[2*DATA_W-1:DATA_W]};
    shifted  = {acc[2*DATA_W:DATA_W], acc[DATA_W-1]};
    trial    = shifted - {2'b00, operand};
    q_bit    = 1'b0;
    acc_next = {1'b0, hi_next, acc[DATA_W-1:1]};
    if (is_div) begin
      q_bit    = ~trial[DATA_W+1];
      acc_next = {(q_bit ? trial[DATA_W:0] : shifted[DATA_W:0]),
                  acc[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; stalls the pipeline
// when an MFHI/MFLO or a new mul/div meets a busy unit.
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  hilo_muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int ACC_W = 2 * DATA_W + 1;

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              signed_op;
  logic [MD_W:0]     abs_a, abs_b;
  logic [ACC_W-1:0]  core_acc_next;
  logic              core_q_bit;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix;
  logic              busy;

  muldiv_iter_core #(.DATA_W(DATA_W)) u_iter (
    .acc      (acc_q),
    .operand  (operand_q),
    .is_div   (is_div_q),
    .acc_next (core_acc_next),
    .q_bit    (core_q_bit)
  );

  always_comb begin
    signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    abs_a     = abs_sign(bus.OperandA, signed_op);
    abs_b     = abs_sign(bus.OperandB, signed_op);
  end

  // Sign fixup of the unsigned result held in the accumulator.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q[2*DATA_W-1:0] : acc_q[2*DATA_W-1:0];
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A flush in the same cycle discards whatever EX offered.
        if (bus.Start && !bus.Kill) begin
          unique case (bus.Op)
            OP_MULT, OP_MULTU: begin
              operand_d = abs_a[DATA_W-1:0];
              acc_d     = {{(DATA_W+1){1'b0}}, abs_b[DATA_W-1:0]};
              sign_a_d  = abs_a[MD_W];
              sign_b_d  = abs_b[MD_W];
              is_div_d  = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = CNT_W'(DATA_W - 1);
              state_d   = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              sign_a_d = abs_a[MD_W];
              sign_b_d = abs_b[MD_W];
              is_div_d = 1'b1;
              cnt_d    = CNT_W'(DATA_W - 1);
              if (bus.OperandB == '0) begin
                // Raw dividend parks in the low half; FIX hands it to HI.
                acc_d   = {{(DATA_W+1){1'b0}}, bus.OperandA};
                div0_d  = 1'b1;
                state_d = S_FIX;
              end else begin
                operand_d = abs_b[DATA_W-1:0];
                acc_d     = {{(DATA_W+1){1'b0}}, abs_a[DATA_W-1:0]};
                div0_d    = 1'b0;
                state_d   = S_DIV;
              end
            end
            OP_MTHI: hi_d = bus.OperandA;
            OP_MTLO: lo_d = bus.OperandA;
            default: ;
          endcase
        end
      end

      S_MUL, S_DIV: begin
        if (bus.Kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? {core_acc_next[ACC_W-1:1], core_q_bit} : core_acc_next;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.Kill) begin
          done_d = 1'b1;
          dbz_d  = div0_q;
          if (div0_q) begin
            hi_d = acc_q[DATA_W-1:0];
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*DATA_W-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  // NOTE: the datapath registers are reset along with the FSM so an aborted
  // operation can never leave stale or unknown data in the accumulator.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign bus.Busy      = busy;
  assign bus.StallReq  = busy & (bus.Start | bus.HiLoRead);
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Self-checking bench for hilo_muldiv_sequencer: directed vector table, random
// mul/div against an arithmetic reference, and stall/kill/reset sequences.
module tb_hilo_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  hilo_muldiv_sequencer_if #(.DATA_W(32)) bus ();

  hilo_muldiv_sequencer #(.DATA_W(32)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    logic [64:0] res;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    res = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; res = {1'b0, p[63:0]}; end
      OP_MULTU: begin up = ua * ub; res = {1'b0, up[63:0]}; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          res = {1'b1, a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          res = {1'b0, r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Issue one op and follow it to the Done cycle (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output logic done_end, output logic done_after, output int busy_n);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = b;
    @(negedge clk);
    bus.Start = 1'b0;
    busy_n = 0;
    while (bus.Busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    hi = bus.HI;
    lo = bus.LO;
    dbz = bus.DivByZero;
    done_end = bus.Done;
    @(negedge clk);
    done_after = bus.Done;
  endtask

  task automatic issue_single(input logic [2:0] op, input logic [31:0] a, input logic kill);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = 32'd1;
    bus.Kill = kill;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Kill = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] hi, lo, prev_hi, prev_lo;
    logic        dbz, done_end, done_after;
    int          busy_n, stall_bad, exp_busy;
    logic [64:0] exp;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 33};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33};
    vecs[5]  = '{OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[6]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 33};
    vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 33};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[9]  = '{OP_MULTU, 32'd0,         32'h1234_5678, 32'd0,        32'd0,         1'b0, 33};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[11] = '{OP_MULT,  32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7, 1'b0, 33};
    vecs[12] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33};

    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.HiLoRead = 1'b0;
    bus.Kill = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(bus.HI), 64'd0);
    check("reset_lo", 64'(bus.LO), 64'd0);
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_dbz", 64'(bus.DivByZero), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, done_end, done_after, busy_n);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(vecs[i].busy));
      check($sformatf("vec%0d_done", i), 64'(done_end), 64'd1);
      check($sformatf("vec%0d_done_once", i), 64'(done_after), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      exp = ref_model(rop, ra, rb);
      exp_busy = (exp[64]) ? 1 : 33;
      run_op(rop, ra, rb, hi, lo, dbz, done_end, done_after, busy_n);
      check($sformatf("rnd%0d_op%0d_%h_%h_hilo", i, rop, ra, rb), {hi, lo}, exp[63:0]);
      check($sformatf("rnd%0d_dbz", i), 64'(dbz), 64'(exp[64]));
      check($sformatf("rnd%0d_busy_cycles", i), 64'(busy_n), 64'(exp_busy));
    end

    // Stall during a multiply; the second Start must be dropped.
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = OP_MULT;
    bus.OperandA = 32'd5;
    bus.OperandB = 32'd6;
    @(negedge clk);
    bus.Op = OP_MULTU;
    bus.OperandA = 32'hFFFF_FFFF;
    bus.OperandB = 32'd2;
    bus.HiLoRead = 1'b1;
    stall_bad = 0;
    busy_n = 0;
    while (bus.Busy && busy_n < 100) begin
      #1;
      if (bus.StallReq !== 1'b1) stall_bad++;
      busy_n++;
      @(negedge clk);
    end
    #1;
    check("stall_every_busy_cycle", 64'(stall_bad), 64'd0);
    check("stall_busy_cycles", 64'(busy_n), 64'd33);
    check("stall_drop_in_done", 64'(bus.StallReq), 64'd0);
    check("stall_done", 64'(bus.Done), 64'd1);
    check("stall_second_start_ignored", {bus.HI, bus.LO}, 64'd30);
    bus.Start = 1'b0;
    bus.HiLoRead = 1'b0;

    // Kill mid-multiply at iteration 10.
    prev_hi = bus.HI;
    prev_lo = bus.LO;
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = OP_MULTU;
    bus.OperandA = 32'hFFFF_FFFF;
    bus.OperandB = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    check("kill_busy_before", 64'(bus.Busy), 64'd1);
    bus.Kill = 1'b1;
    @(negedge clk);
    bus.Kill = 1'b0;
    check("kill_busy_after", 64'(bus.Busy), 64'd0);
    check("kill_no_done", 64'(bus.Done), 64'd0);
    check("kill_hilo_held", {bus.HI, bus.LO}, {prev_hi, prev_lo});
    @(negedge clk);
    check("kill_no_late_done", 64'(bus.Done), 64'd0);

    // Kill while in FIX (divide by zero goes straight there).
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = OP_DIVU;
    bus.OperandA = 32'h55;
    bus.OperandB = 32'd0;
    @(negedge clk);
    bus.Start = 1'b0;
    check("killfix_busy", 64'(bus.Busy), 64'd1);
    bus.Kill = 1'b1;
    @(negedge clk);
    bus.Kill = 1'b0;
    check("killfix_idle", 64'(bus.Busy), 64'd0);
    check("killfix_no_done", {63'd0, bus.Done | bus.DivByZero}, 64'd0);
    check("killfix_hilo_held", {bus.HI, bus.LO}, {prev_hi, prev_lo});

    // Asynchronous reset at iteration 5.
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op = OP_MULT;
    bus.OperandA = 32'd3;
    bus.OperandB = 32'd4;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.Busy), 64'd0);
    check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
    check("rst_mid_done", 64'(bus.Done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Moves into HI/LO, a killed MTLO, and ignored op codes.
    issue_single(OP_MTLO, 32'h1111, 1'b0);
    check("mtlo_lo", 64'(bus.LO), 64'h1111);
    check("mtlo_no_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    issue_single(OP_MTHI, 32'h2222, 1'b0);
    check("mthi_hi", 64'(bus.HI), 64'h2222);
    issue_single(OP_MTLO, 32'hCAFE, 1'b1);
    check("mtlo_killed", 64'(bus.LO), 64'h1111);
    issue_single(3'd6, 32'hABCD, 1'b0);
    check("op6_ignored", {bus.HI, bus.LO}, {32'h2222, 32'h1111});
    check("op6_no_busy", 64'(bus.Busy), 64'd0);
    issue_single(3'd7, 32'hABCD, 1'b0);
    check("op7_ignored", {bus.HI, bus.LO}, {32'h2222, 32'h1111});
    bus.HiLoRead = 1'b1;
    #1;
    check("idle_hiloread_no_stall", 64'(bus.StallReq), 64'd0);
    bus.HiLoRead = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
